dmem_ctrl: RTL and testbench

- Parametrised data-memory block that replaces the fixed 1K-word combinational data RAM on the CPU data port.
- Adds byte, halfword and word access with sign or zero extension on loads.
- Adds detection of misaligned and out-of-window accesses.
- Adds a valid/ready request/response handshake with a configurable access latency, and a debug word port.
- Sits between the MEM stage / multi-cycle controller and the CPU data bus.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 48 ++++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller.
// Size codes follow the CPU data-port req_size field.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated write data, load extract + extend.
// Purely combinational; no handshake.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_rshift;

    always_comb begin
        o_be     = 4'b0000;
        o_wdata  = 32'h0;
        o_rdata  = 32'h0;
        w_rshift = i_rword >> {i_lane, 3'b000};
        // Write data is replicated across lanes so the byte enables alone pick the target lanes.
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_rshift[7]}}, w_rshift[7:0]};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << i_lane;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_rshift[15]}}, w_rshift[15:0]};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = 32'h0;
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory with byte/half/word access, fault checks and valid/ready request/response.
// Response appears LATENCY cycles after accept and is held until rsp_ready; one access in flight.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned DEBUG_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] dbg_word
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);
    localparam logic [AW-1:0] DBG_I   = AW'(DEBUG_IDX);

    logic [31:0] r_mem [DEPTH];

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic [31:0]   w_off;
    logic          w_in_range;
    logic          w_aligned;
    logic          w_fault;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_accept;
    logic          w_wr_en;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_ld_data;
    logic [31:0]   w_rword;

    assign w_off      = req_addr - BASE_ADDR;
    assign w_in_range = (req_addr >= BASE_ADDR) && (w_off < WIN_BYTES);
    assign w_idx      = w_off[AW+1:2];
    assign w_lane     = w_off[1:0];

    always_comb begin
        w_aligned = 1'b0;
        case (size_e'(req_size))
            SZ_BYTE: w_aligned = 1'b1;
            SZ_HALF: w_aligned = ~w_lane[0];
            SZ_WORD: w_aligned = (w_lane == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_fault   = ~w_in_range | ~w_aligned | (req_size == SZ_ILLEGAL);
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign w_accept  = req_valid & req_ready & ~rst;
    assign w_wr_en   = w_accept & req_we & ~w_fault;
    assign w_rword   = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size   (req_size),
        .i_lane   (w_lane),
        .i_signed (req_signed),
        .i_wdata  (req_wdata),
        .i_rword  (w_rword),
        .o_be     (w_be),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_ld_data)
    );

    // Array has no reset: contents survive rst, including a store accepted just before it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata_sh[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault || (LATENCY == 1)) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (w_fault || req_we) ? 32'h0 : w_ld_data;
            r_fault <= w_fault;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_fault = r_fault;
    assign dbg_word  = r_mem[DBG_I];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a driver pushes expected responses, a monitor pops and compares.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int          LAT = 4;
    localparam int          DBG = 3;
    localparam logic [31:0] B   = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] dbg_word;

    dmem_ctrl #(
        .DEPTH     (1024),
        .BASE_ADDR (B),
        .LATENCY   (LAT),
        .DEBUG_IDX (DBG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .dbg_word   (dbg_word)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        int          lat;
        int          stall;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   last_hs  = -100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares on first sight of rsp_valid, then holds rsp_ready low for the requested stall.
    logic        busy = 1'b0;
    int          stall = 0;
    logic [31:0] held = 32'h0;
    exp_t        cur;

    always @(negedge clk) begin
        if (rst) begin
            busy      = 1'b0;
            rsp_ready = 1'b0;
        end else if (rsp_valid) begin
            if (!busy) begin
                busy = 1'b1;
                held = rsp_rdata;
                if (q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
                    stall = 0;
                end else begin
                    cur = q.pop_front();
                    chk("rsp_latency", 32'(cyc + 1 - cur.acc), 32'(cur.lat));
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    chk("rsp_fault", 32'(rsp_fault), 32'(cur.fault));
                    stall = cur.stall;
                end
            end else begin
                chk("rdata_stable", rsp_rdata, held);
                chk("req_ready_low_in_resp", 32'(req_ready), 32'h0);
            end
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else begin
                rsp_ready = 1'b1;
                last_hs   = cyc + 1;
                busy      = 1'b0;
            end
        end else begin
            rsp_ready = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge with req_* scrambled.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_f,
                         input int stl, input bit push, input bit b2b);
        int   acc;
        int   n;
        exp_t e;
        n          = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (b2b) chk("b2b_accept_cycle", 32'(acc), 32'(last_hs + 1));
        if (push) begin
            e.rdata = exp_rd;
            e.fault = exp_f;
            e.acc   = acc;
            e.lat   = exp_f ? 1 : LAT;
            e.stall = stl;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        chk("req_ready_after_accept", 32'(req_ready), 32'h0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'h0);

        // we, size, signed, addr, wdata, expected rdata, expected fault, stall, push, b2b
        issue(1, SZ_WORD, 0, B + 4,    32'hDEADBEEF, 32'h0,        0, 0, 1, 0);
        issue(0, SZ_WORD, 0, B + 4,    32'h0,        32'hDEADBEEF, 0, 0, 1, 0);
        issue(1, SZ_WORD, 0, B + 8,    32'h0,        32'h0,        0, 0, 1, 0);
        issue(1, SZ_BYTE, 0, B + 8,    32'hAAAA5580, 32'h0,        0, 0, 1, 0);
        issue(1, SZ_BYTE, 0, B + 9,    32'h1234567F, 32'h0,        0, 0, 1, 0);
        issue(0, SZ_BYTE, 1, B + 8,    32'h0,        32'hFFFFFF80, 0, 0, 1, 0);
        issue(0, SZ_BYTE, 0, B + 8,    32'h0,        32'h00000080, 0, 0, 1, 0);
        issue(0, SZ_WORD, 0, B + 8,    32'h0,        32'h00007F80, 0, 0, 1, 0);
        issue(0, SZ_BYTE, 1, B + 9,    32'h0,        32'h0000007F, 0, 0, 1, 0);
        issue(1, SZ_HALF, 0, B + 10,   32'h1234ABCD, 32'h0,        0, 0, 1, 0);
        issue(0, SZ_HALF, 1, B + 10,   32'h0,        32'hFFFFABCD, 0, 0, 1, 0);
        issue(0, SZ_HALF, 0, B + 10,   32'h0,        32'h0000ABCD, 0, 0, 1, 0);
        issue(0, SZ_HALF, 1, B + 8,    32'h0,        32'h00007F80, 0, 0, 1, 0);

        // Faults: misaligned, below window, one past window, illegal size, faulting stores
        issue(0, SZ_HALF,    0, B + 3,        32'h0,        32'h0, 1, 0, 1, 0);
        issue(0, SZ_WORD,    0, B + 2,        32'h0,        32'h0, 1, 0, 1, 0);
        issue(0, SZ_WORD,    0, 32'h1000FFFC, 32'h0,        32'h0, 1, 0, 1, 0);
        issue(0, SZ_WORD,    0, B + 4096,     32'h0,        32'h0, 1, 0, 1, 0);
        issue(0, SZ_ILLEGAL, 0, B + 4,        32'h0,        32'h0, 1, 0, 1, 0);
        issue(1, SZ_WORD,    0, B + 6,        32'h11111111, 32'h0, 1, 0, 1, 0);
        issue(1, SZ_ILLEGAL, 0, B + 4,        32'h22222222, 32'h0, 1, 0, 1, 0);
        issue(1, SZ_BYTE,    0, 32'h1000FFFF, 32'h33333333, 32'h0, 1, 0, 1, 0);
        issue(0, SZ_WORD,    0, B + 4,        32'h0,        32'hDEADBEEF, 0, 0, 1, 0);

        // Last word of the window
        issue(1, SZ_WORD, 0, B + 32'hFFC, 32'hCAFEF00D, 32'h0,        0, 0, 1, 0);
        issue(0, SZ_WORD, 0, B + 32'hFFC, 32'h0,        32'hCAFEF00D, 0, 0, 1, 0);
        issue(0, SZ_BYTE, 1, B + 32'hFFF, 32'h0,        32'hFFFFFFCA, 0, 0, 1, 0);

        // Consumer stalls three cycles; next request must go in the cycle after the handshake
        issue(0, SZ_WORD, 0, B + 4, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0);
        issue(0, SZ_WORD, 0, B + 8, 32'h0, 32'hABCD7F80, 0, 0, 1, 1);

        // Reset while waiting on a store to the debug word
        issue(1, SZ_WORD, 0, B + 32'(DBG * 4), 32'h5A5AA5A5, 32'h0, 0, 0, 0, 0);
        chk("dbg_word_after_store", dbg_word, 32'h5A5AA5A5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midop_reset_req_ready", 32'(req_ready), 32'h1);
        chk("midop_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midop_reset_dbg_word", dbg_word, 32'h5A5AA5A5);
        repeat (6) @(negedge clk);
        issue(0, SZ_WORD, 0, B + 32'(DBG * 4), 32'h0, 32'h5A5AA5A5, 0, 0, 1, 0);

        n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'h0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
